// File: rtl/id_decode_queue.sv
// Decodes MIPS-I fetch words and buffers them in a DEPTH-entry FIFO with branch-delay-slot tags.
// Defining DQ_BYPASS_EN enables a same-cycle path from a fetch word to an empty queue's output.
module id_decode_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_W-1:0]      in_pc,
    input  logic [31:0]            in_inst,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_W-1:0]      out_pc,
    output logic [31:0]            out_inst,
    output logic [3:0]             out_cls,
    output logic [4:0]             out_rs,
    output logic [4:0]             out_rt,
    output logic [4:0]             out_rd,
    output logic                   out_sy,
    output logic                   out_bp,
    output logic                   out_er,
    output logic                   out_ri,
    output logic                   out_bd,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [3:0] CLS_ALU    = 4'd0;
    localparam logic [3:0] CLS_MULDIV = 4'd1;
    localparam logic [3:0] CLS_HILO   = 4'd2;
    localparam logic [3:0] CLS_BRANCH = 4'd3;
    localparam logic [3:0] CLS_JUMP   = 4'd4;
    localparam logic [3:0] CLS_LOAD   = 4'd5;
    localparam logic [3:0] CLS_STORE  = 4'd6;
    localparam logic [3:0] CLS_COP0   = 4'd7;
    localparam logic [3:0] CLS_TRAP   = 4'd8;
    localparam logic [3:0] CLS_RI     = 4'd15;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       inst;
        logic [3:0]        cls;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic              sy;
        logic              bp;
        logic              er;
        logic              ri;
        logic              bd;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            bd_pending_q, bd_pending_d;

    entry_t          dec;
    entry_t          head;
    logic            legal;
    logic            empty, bypass, accept, wr_en, pop;

    logic [5:0] op, funct;
    logic [4:0] f_rs, f_rt, f_rd;

    assign op    = in_inst[31:26];
    assign f_rs  = in_inst[25:21];
    assign f_rt  = in_inst[20:16];
    assign f_rd  = in_inst[15:11];
    assign funct = in_inst[5:0];

    always_comb begin
        dec      = '0;
        dec.pc   = in_pc;
        dec.inst = in_inst;
        dec.bd   = bd_pending_q;
        legal    = 1'b1;
        unique case (op)
            6'h00: begin
                dec.rs = f_rs;
                dec.rt = f_rt;
                dec.rd = f_rd;
                unique case (funct)
                    6'h00, 6'h02, 6'h03: begin
                        dec.cls = CLS_ALU;
                        dec.rs  = '0;
                    end
                    6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
                    6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: dec.cls = CLS_ALU;
                    6'h08: begin
                        dec.cls = CLS_JUMP;
                        dec.rd  = '0;
                    end
                    6'h09: begin
                        dec.cls = CLS_JUMP;
                        dec.rd  = (f_rd == 5'd0) ? 5'd31 : f_rd;
                    end
                    6'h0c, 6'h0d: begin
                        // The rs/rt/rd fields hold the trap code here, not registers.
                        dec.cls = CLS_TRAP;
                        dec.sy  = (funct == 6'h0c);
                        dec.bp  = (funct == 6'h0d);
                        dec.rs  = '0;
                        dec.rt  = '0;
                        dec.rd  = '0;
                    end
                    6'h10, 6'h11, 6'h12, 6'h13: dec.cls = CLS_HILO;
                    6'h18, 6'h19, 6'h1a, 6'h1b: dec.cls = CLS_MULDIV;
                    default: legal = 1'b0;
                endcase
            end
            6'h01: begin
                dec.cls = CLS_BRANCH;
                dec.rs  = f_rs;
                unique case (f_rt)
                    5'h00, 5'h01: dec.rd = '0;
                    5'h10, 5'h11: dec.rd = 5'd31;
                    default:      legal  = 1'b0;
                endcase
            end
            6'h02: dec.cls = CLS_JUMP;
            6'h03: begin
                dec.cls = CLS_JUMP;
                dec.rd  = 5'd31;
            end
            6'h04, 6'h05, 6'h06, 6'h07: begin
                dec.cls = CLS_BRANCH;
                dec.rs  = f_rs;
                dec.rt  = f_rt;
            end
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
                dec.cls = CLS_ALU;
                dec.rs  = f_rs;
                dec.rd  = f_rt;
            end
            6'h10: begin
                dec.cls = CLS_COP0;
                unique case (f_rs)
                    5'h00:   dec.rd = f_rt;
                    5'h04:   dec.rt = f_rt;
                    5'h10:   begin
                        if (funct == 6'h18) dec.er = 1'b1;
                        else                legal  = 1'b0;
                    end
                    default: legal = 1'b0;
                endcase
            end
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: begin
                dec.cls = CLS_LOAD;
                dec.rs  = f_rs;
                dec.rd  = f_rt;
            end
            6'h28, 6'h29, 6'h2a, 6'h2b, 6'h2e: begin
                dec.cls = CLS_STORE;
                dec.rs  = f_rs;
                dec.rt  = f_rt;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec.cls = CLS_RI;
            dec.ri  = 1'b1;
            dec.rs  = '0;
            dec.rt  = '0;
            dec.rd  = '0;
            dec.sy  = 1'b0;
            dec.bp  = 1'b0;
            dec.er  = 1'b0;
        end
    end

    assign empty    = (count_q == '0);
    assign in_ready = (count_q != FULL);

`ifdef DQ_BYPASS_EN
    assign bypass = empty & in_valid & ~flush;
`else
    assign bypass = 1'b0;
`endif

    assign accept    = in_valid & in_ready & ~flush;
    // A bypassed word that is consumed immediately never occupies a slot.
    assign wr_en     = accept & ~(bypass & out_ready);
    assign pop       = ~empty & out_ready & ~flush;
    assign out_valid = ~empty | bypass;
    assign head      = bypass ? dec : mem_q[rd_ptr_q];

    assign out_pc   = head.pc;
    assign out_inst = head.inst;
    assign out_cls  = head.cls;
    assign out_rs   = head.rs;
    assign out_rt   = head.rt;
    assign out_rd   = head.rd;
    assign out_sy   = head.sy;
    assign out_bp   = head.bp;
    assign out_er   = head.er;
    assign out_ri   = head.ri;
    assign out_bd   = head.bd;
    assign count    = count_q;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        bd_pending_d = bd_pending_q;
        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            bd_pending_d = 1'b0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({wr_en, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (accept) bd_pending_d = (dec.cls == CLS_BRANCH) | (dec.cls == CLS_JUMP);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            bd_pending_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            bd_pending_q <= bd_pending_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en && !flush) begin
            mem_q[wr_ptr_q] <= dec;
        end
    end

endmodule

// File: tb/tb_id_decode_queue.sv
// Scoreboard bench for id_decode_queue: directed decode vectors, full/wrap, flush, async reset.
module tb_id_decode_queue;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [3:0]  cls;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [3:0]  fl;   // sy, bp, er, ri
        logic        bd;
    } exp_t;

    logic        clk, resetn, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_pc, in_inst, out_pc, out_inst;
    logic [3:0]  out_cls;
    logic [4:0]  out_rs, out_rt, out_rd;
    logic        out_sy, out_bp, out_er, out_ri, out_bd;
    logic [2:0]  count;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t expq[$];

    id_decode_queue #(.DEPTH(4), .ADDR_W(32)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_cls(out_cls), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_sy(out_sy), .out_bp(out_bp), .out_er(out_er), .out_ri(out_ri),
        .out_bd(out_bd), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] inst, input logic [3:0] cls,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [3:0] fl);
        exp_t e;
        e      = '0;
        e.inst = inst;
        e.cls  = cls;
        e.rs   = rs;
        e.rt   = rt;
        e.rd   = rd;
        e.fl   = fl;
        return e;
    endfunction

    // Monitor: every handshake the DUT completes is matched against the scoreboard head.
    always @(negedge clk) begin
        if (resetn && out_valid && out_ready && !flush) begin
            if (expq.size() == 0) begin
                check("unexpected_pop", 88'(out_inst), 88'h0);
                if (out_inst == 32'h0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pop: got entry with pc %0h, expected none", out_pc);
                end
            end else begin
                check("entry", {out_pc, out_inst, out_cls, out_rs, out_rt, out_rd,
                                out_sy, out_bp, out_er, out_ri, out_bd}, expq.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input exp_t e_in, input logic [31:0] pc, input logic bd,
                        output logic ok);
        exp_t e;
        e    = e_in;
        e.pc = pc;
        e.bd = bd;
        expq.push_back(e);
        in_pc    = pc;
        in_inst  = e.inst;
        in_valid = 1'b1;
        @(negedge clk);
        ok = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ok) void'(expq.pop_back());
    endtask

    task automatic drain;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (count == 3'd0) break;
            tick(1);
        end
        out_ready = 1'b0;
        check("drain_count", 88'(count), 88'd0);
    endtask

    exp_t v_addu, v_lw, v_sw, v_beq, v_lui, v_mult, v_mfhi, v_mfc0, v_mtc0, v_eret;
    exp_t v_brk, v_bgezal, v_jalr, v_sll, v_ri_op, v_ri_fn, v_ri_rim, v_sys, v_jal, v_nop;
    logic ok;

    initial begin
        v_addu   = mk(32'h00221821, 4'd0,  5'd1, 5'd2, 5'd3,  4'b0000);
        v_lw     = mk(32'h8C430004, 4'd5,  5'd2, 5'd0, 5'd3,  4'b0000);
        v_sw     = mk(32'hAC430004, 4'd6,  5'd2, 5'd3, 5'd0,  4'b0000);
        v_beq    = mk(32'h10220005, 4'd3,  5'd1, 5'd2, 5'd0,  4'b0000);
        v_lui    = mk(32'h3C01BFC0, 4'd0,  5'd0, 5'd0, 5'd1,  4'b0000);
        v_mult   = mk(32'h00430018, 4'd1,  5'd2, 5'd3, 5'd0,  4'b0000);
        v_mfhi   = mk(32'h00001010, 4'd2,  5'd0, 5'd0, 5'd2,  4'b0000);
        v_mfc0   = mk(32'h40026000, 4'd7,  5'd0, 5'd0, 5'd2,  4'b0000);
        v_mtc0   = mk(32'h40826000, 4'd7,  5'd0, 5'd2, 5'd0,  4'b0000);
        v_eret   = mk(32'h42000018, 4'd7,  5'd0, 5'd0, 5'd0,  4'b0010);
        v_brk    = mk(32'h0000000D, 4'd8,  5'd0, 5'd0, 5'd0,  4'b0100);
        v_sys    = mk(32'h0000000C, 4'd8,  5'd0, 5'd0, 5'd0,  4'b1000);
        v_bgezal = mk(32'h04110004, 4'd3,  5'd0, 5'd0, 5'd31, 4'b0000);
        v_jalr   = mk(32'h00400009, 4'd4,  5'd2, 5'd0, 5'd31, 4'b0000);
        v_sll    = mk(32'h00021080, 4'd0,  5'd0, 5'd2, 5'd2,  4'b0000);
        v_jal    = mk(32'h0C000010, 4'd4,  5'd0, 5'd0, 5'd31, 4'b0000);
        v_nop    = mk(32'h00000000, 4'd0,  5'd0, 5'd0, 5'd0,  4'b0000);
        v_ri_op  = mk(32'hFC000000, 4'd15, 5'd0, 5'd0, 5'd0,  4'b0001);
        v_ri_fn  = mk(32'h0022183F, 4'd15, 5'd0, 5'd0, 5'd0,  4'b0001);
        v_ri_rim = mk(32'h04250000, 4'd15, 5'd0, 5'd0, 5'd0,  4'b0001);

        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst = '0;
        #3;
        check("reset_count",     88'(count),     88'd0);
        check("reset_out_valid", 88'(out_valid), 88'd0);
        check("reset_in_ready",  88'(in_ready),  88'd1);
        check("reset_fields", {out_pc, out_inst, out_cls, out_rs, out_rt, out_rd,
                               out_sy, out_bp, out_er, out_ri, out_bd}, 88'd0);
        tick(2);
        resetn = 1'b1;
        tick(1);

        // Single addu, one-cycle latency.
        push(v_addu, 32'hBFC00000, 1'b0, ok);
        check("addu_out_valid", 88'(out_valid), 88'd1);
        check("addu_count",     88'(count),     88'd1);
        check("addu_cls_rd",    88'({out_cls, out_rd}), 88'({4'd0, 5'd3}));
        drain();

        // jal then two nops: delay-slot tag only on the first nop.
        push(v_jal, 32'h00000100, 1'b0, ok);
        push(v_nop, 32'h00000104, 1'b1, ok);
        push(v_nop, 32'h00000108, 1'b0, ok);
        check("jal_count", 88'(count), 88'd3);
        drain();

        // Fill to DEPTH, fifth word refused, head stable while stalled.
        for (int i = 0; i < 4; i++) push(v_addu, 32'h200 + 32'(4 * i), 1'b0, ok);
        check("full_count",    88'(count),    88'd4);
        check("full_in_ready", 88'(in_ready), 88'd0);
        push(v_lw, 32'h00000210, 1'b0, ok);
        check("fifth_refused", 88'(ok),     88'd0);
        check("fifth_count",   88'(count),  88'd4);
        check("stall_head_pc", 88'(out_pc), 88'h200);
        out_ready = 1'b1;
        tick(1);
        check("drain_one", 88'(count), 88'd3);

        // Concurrent push/pop across pointer wrap.
        push(v_lw,     32'h300, 1'b0, ok); check("wrap_count0", 88'(count), 88'd3);
        push(v_sw,     32'h304, 1'b0, ok); check("wrap_count1", 88'(count), 88'd3);
        push(v_beq,    32'h308, 1'b0, ok); check("wrap_count2", 88'(count), 88'd3);
        push(v_lui,    32'h30C, 1'b1, ok); check("wrap_count3", 88'(count), 88'd3);
        push(v_mult,   32'h310, 1'b0, ok); check("wrap_count4", 88'(count), 88'd3);
        push(v_mfhi,   32'h314, 1'b0, ok); check("wrap_count5", 88'(count), 88'd3);
        push(v_bgezal, 32'h318, 1'b0, ok); check("wrap_count6", 88'(count), 88'd3);
        push(v_jalr,   32'h31C, 1'b1, ok); check("wrap_count7", 88'(count), 88'd3);
        drain();

        // Reserved instruction, syscall and the remaining decode classes.
        out_ready = 1'b1;
        push(v_ri_op,  32'h400, 1'b1, ok);
        push(v_sys,    32'h404, 1'b0, ok);
        push(v_mfc0,   32'h408, 1'b0, ok);
        push(v_mtc0,   32'h40C, 1'b0, ok);
        push(v_eret,   32'h410, 1'b0, ok);
        push(v_brk,    32'h414, 1'b0, ok);
        push(v_sll,    32'h418, 1'b0, ok);
        push(v_ri_fn,  32'h41C, 1'b0, ok);
        push(v_ri_rim, 32'h420, 1'b0, ok);
        drain();

        // Flush with concurrent push and pop; delay-slot state must be cleared.
        push(v_addu, 32'h500, 1'b0, ok);
        push(v_addu, 32'h504, 1'b0, ok);
        push(v_beq,  32'h508, 1'b0, ok);
        check("preflush_count", 88'(count), 88'd3);
        expq.delete();
        flush = 1'b1; in_valid = 1'b1; in_inst = v_lui.inst; in_pc = 32'h50C; out_ready = 1'b1;
        tick(1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("flush_count",     88'(count),     88'd0);
        check("flush_out_valid", 88'(out_valid), 88'd0);
        push(v_lui, 32'h600, 1'b0, ok);
        check("postflush_count", 88'(count), 88'd1);
        drain();

        // Asynchronous reset mid-cycle.
        push(v_addu, 32'h700, 1'b0, ok);
        push(v_sw,   32'h704, 1'b0, ok);
        #2 resetn = 1'b0;
        #1;
        check("async_count",     88'(count),     88'd0);
        check("async_out_valid", 88'(out_valid), 88'd0);
        check("async_out_pc",    88'(out_pc),    88'd0);
        expq.delete();
        tick(1);
        resetn = 1'b1;
        tick(1);

`ifdef DQ_BYPASS_EN
        begin
            exp_t e;
            e = v_lw; e.pc = 32'h800; e.bd = 1'b0;
            expq.push_back(e);
            out_ready = 1'b1; in_valid = 1'b1; in_inst = v_lw.inst; in_pc = 32'h800;
            #1;
            check("bypass_out_valid", 88'(out_valid), 88'd1);
            check("bypass_fields", 88'({out_cls, out_rs, out_rd}), 88'({4'd5, 5'd2, 5'd3}));
            tick(1);
            in_valid = 1'b0; out_ready = 1'b0;
            check("bypass_count", 88'(count), 88'd0);
        end
`endif

        tick(2);
        check("scoreboard_empty", 88'(expq.size()), 88'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
